serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  // Operation sequencing: wait for operands, shift WIDTH bits, hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit count wide enough to hold 0..w so the counter never wraps.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = A - B - C, borrow set when A < B + C.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic diff,
  output logic borrow
);

  // Pure combinational cell; C is the incoming borrow.
  always_comb begin
    diff   = A ^ B ^ C;
    borrow = (~A & (B | C)) | (B & C);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = A - B - bin, one bit per clock,
// LSB first, with valid/ready handshakes on operands and result.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fs_diff;
  logic             fs_borrow;

  // Single subtract cell works on the current LSBs and the running borrow.
  full_subtractor u_fs (
    .A      (a_q[0]),
    .B      (b_q[0]),
    .C      (br_q),
    .diff   (fs_diff),
    .borrow (fs_borrow)
  );

  // State, operand/result shift registers, borrow flop and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    br_d      = br_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Result bits enter at the MSB so bit 0 lands in diff[0] after WIDTH shifts.
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        diff_d = {fs_diff, diff_q[WIDTH-1:1]};
        br_d   = fs_borrow;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The borrow flop holds the final borrow-out once the shift completes.
  assign diff   = diff_q;
  assign borrow = br_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors,
// backpressure, asynchronous reset and a randomized sweep against an
// arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int errors = 0;
  int checks = 0;
  int op_num = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    in_valid = 1'($urandom);
    A        = WIDTH'($urandom);
    B        = WIDTH'($urandom);
    bin      = 1'($urandom);
  endtask

  // Runs one operation starting at a negedge in IDLE; ends at a negedge in IDLE.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bi, input int stall);
    logic [WIDTH:0] ref_r;
    int lat;
    int guard;
    ref_r = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bi);

    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);

    A = a; B = b; bin = bi; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    scramble_inputs();

    lat = 0;
    while (!out_valid && lat < 4 * WIDTH) begin
      check_eq("run_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
      scramble_inputs();
    end
    check_eq("latency", 32'(lat), 32'(WIDTH));
    check_eq("diff", 32'(diff), 32'(ref_r[WIDTH-1:0]));
    check_eq("borrow", 32'(borrow), 32'(ref_r[WIDTH]));

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      scramble_inputs();
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_diff", 32'(diff), 32'(ref_r[WIDTH-1:0]));
      check_eq("stall_borrow", 32'(borrow), 32'(ref_r[WIDTH]));
    end

    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("post_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_diff_hold", 32'(diff), 32'(ref_r[WIDTH-1:0]));

    op_num++;
    $display("op %0d: A=%02h B=%02h bin=%0d -> diff=%02h borrow=%0d (ref %02h/%0d) stall=%0d",
             op_num, a, b, bi, diff, borrow, ref_r[WIDTH-1:0], ref_r[WIDTH], stall);
  endtask

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors and boundaries.
    run_op(8'h5A, 8'h21, 1'b0, 0);
    run_op(8'h10, 8'h20, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b1, 0);
    run_op(8'h80, 8'h7F, 1'b1, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    // Backpressure with input toggling in DONE.
    run_op(8'h5A, 8'h21, 1'b0, 5);

    // Asynchronous reset three edges into RUN.
    A = 8'h0F; B = 8'hF0; bin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_diff", 32'(diff), 32'd0);
    check_eq("mid_rst_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    run_op(8'hFF, 8'h01, 1'b0, 0);

    // Asynchronous reset while a result is held in DONE.
    A = 8'h33; B = 8'h11; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 4 * WIDTH) begin
      @(negedge clk);
      guard++;
    end
    check_eq("done_reach", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("done_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("done_rst_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("done_rst_in_ready", 32'(in_ready), 32'd1);

    // Randomized sweep with random output stalls.
    for (int i = 0; i < 1000; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
